req_priority_arbiter: RTL



---
 rtl/req_priority_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/req_priority_arbiter.sv
// req_priority_arbiter: 8-way arbiter with fixed-priority/round-robin selection and hold timeout.
module req_priority_arbiter #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     rr_mode,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     gnt_valid,
  output logic                     timeout
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [N_REQ-1:0] mask, mask_n, gnt_n, base, cand;
  logic [IW-1:0] last_id, last_n, id_n, win, idx;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic valid_n, to_n, expire;
  always_comb begin
    base = req & ~mask;
    cand = (base == '0) ? req : base;
    win = '0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (cand[i]) win = IW'(i);
    // Search downward from the farthest offset so the nearest index after last_id wins.
    if (rr_mode) for (int k = N_REQ; k >= 1; k--) begin
      idx = last_id + IW'(k);
      if (cand[idx]) win = idx;
    end
    expire = (MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD - 1));
    state_n = state;
    gnt_n = gnt;
    id_n = gnt_id;
    valid_n = gnt_valid;
    to_n = 1'b0;
    mask_n = mask;
    last_n = last_id;
    cnt_n = cnt;
    if (state == IDLE) begin
      if (cand != '0) begin
        state_n = GRANT;
        gnt_n = {{(N_REQ-1){1'b0}}, 1'b1} << win;
        id_n = win;
        valid_n = 1'b1;
        last_n = win;
        cnt_n = '0;
        mask_n = '0;
      end
    end else begin
      cnt_n = cnt + 1'b1;
      if (!req[gnt_id] || expire) begin
        state_n = IDLE;
        gnt_n = '0;
        id_n = '0;
        valid_n = 1'b0;
        to_n = req[gnt_id];
        mask_n = req[gnt_id] ? gnt : mask;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      gnt_valid <= 1'b0;
      timeout <= 1'b0;
      mask <= '0;
      last_id <= IW'(N_REQ - 1);
      cnt <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      gnt_id <= id_n;
      gnt_valid <= valid_n;
      timeout <= to_n;
      mask <= mask_n;
      last_id <= last_n;
      cnt <= cnt_n;
    end
  end
endmodule
